// File: rtl/vc_fifo_if.sv
// Handshake and status bundle between a NoC port and its virtual-channel input FIFO.
interface vc_fifo_if #(
  parameter int DATA_W   = 36,
  parameter int VC_NUM   = 4,
  parameter int VC_DEPTH = 16
);
  localparam int VCW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int CW  = $clog2(VC_DEPTH) + 1;

  logic                 write_req;
  logic [VCW-1:0]       write_vc;
  logic [DATA_W-1:0]    packet_in;
  logic                 write_gnt;
  logic                 read_req;
  logic [VCW-1:0]       read_vc;
  logic                 read_gnt;
  logic [DATA_W-1:0]    packet_out;
  logic [VC_NUM-1:0]    full;
  logic [VC_NUM-1:0]    empty;
  logic [VC_NUM-1:0]    almost_full;
  logic [VC_NUM*CW-1:0] count;
  logic                 overflow_err;
  logic                 underflow_err;

  // Requester side
  modport master (
    output write_req, write_vc, packet_in, read_req, read_vc,
    input  write_gnt, read_gnt, packet_out, full, empty, almost_full, count,
           overflow_err, underflow_err
  );

  // FIFO side
  modport slave (
    input  write_req, write_vc, packet_in, read_req, read_vc,
    output write_gnt, read_gnt, packet_out, full, empty, almost_full, count,
           overflow_err, underflow_err
  );
endinterface

// File: rtl/vc_fifo.sv
// Multi-VC input FIFO: VC_NUM independent queues sharing one storage array,
// req/gnt handshake with optional one-grant-per-request write pacing.
module vc_fifo #(
  parameter int DATA_W    = 36,
  parameter int VC_NUM    = 4,
  parameter int VC_DEPTH  = 16,
  parameter int AF_LEVEL  = 2,
  parameter int PULSE_GNT = 1
) (
  input logic       clk,
  input logic       rst,
  vc_fifo_if.slave  bus
);
  localparam int VCW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int CW  = $clog2(VC_DEPTH) + 1;
  localparam int IW  = CW - 1;
  localparam int AW  = VCW + IW;

  logic [CW-1:0]        wr_ptr_q [VC_NUM];
  logic [CW-1:0]        wr_ptr_d [VC_NUM];
  logic [CW-1:0]        rd_ptr_q [VC_NUM];
  logic [CW-1:0]        rd_ptr_d [VC_NUM];
  logic [CW-1:0]        occ      [VC_NUM];
  logic [DATA_W-1:0]    mem_q    [VC_NUM*VC_DEPTH];

  logic [VC_NUM-1:0]    full_c, empty_c, af_c;
  logic [VC_NUM*CW-1:0] count_c;

  logic                 wr_en_q;
  logic                 write_gnt_q, read_gnt_q;
  logic [DATA_W-1:0]    packet_out_q;
  logic                 overflow_q, underflow_q;

  logic                 wr_vc_ok, rd_vc_ok;
  logic                 wa, ra, ovf_set, udf_set;
  logic [AW-1:0]        waddr, raddr;

  // Per-VC status straight from the registered pointers; MSB is the wrap bit.
  for (genvar i = 0; i < VC_NUM; i++) begin : g_flags
    assign occ[i]     = wr_ptr_q[i] - rd_ptr_q[i];
    assign empty_c[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
    assign full_c[i]  = (wr_ptr_q[i][IW-1:0] == rd_ptr_q[i][IW-1:0]) &&
                        (wr_ptr_q[i][IW] != rd_ptr_q[i][IW]);
    assign af_c[i]    = (CW'(VC_DEPTH) - occ[i]) <= CW'(AF_LEVEL);
    assign count_c[i*CW +: CW] = occ[i];
  end

  // Out-of-range VC selects are silently ignored.
  assign wr_vc_ok = 32'(bus.write_vc) < VC_NUM;
  assign rd_vc_ok = 32'(bus.read_vc) < VC_NUM;

  assign wa = !rst && bus.write_req && wr_vc_ok && !full_c[bus.write_vc] && wr_en_q;
  assign ra = !rst && bus.read_req && rd_vc_ok && !empty_c[bus.read_vc];
  assign ovf_set = bus.write_req && wr_vc_ok && full_c[bus.write_vc] && wr_en_q;
  assign udf_set = bus.read_req && rd_vc_ok && empty_c[bus.read_vc];

  assign waddr = {bus.write_vc, wr_ptr_q[bus.write_vc][IW-1:0]};
  assign raddr = {bus.read_vc, rd_ptr_q[bus.read_vc][IW-1:0]};

  // Pointer advance for the accepted write and read of this cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wa) wr_ptr_d[bus.write_vc] = wr_ptr_q[bus.write_vc] + CW'(1);
    if (ra) rd_ptr_d[bus.read_vc] = rd_ptr_q[bus.read_vc] + CW'(1);
  end

  // Pointers, grants, read data and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VC_NUM; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      write_gnt_q  <= 1'b0;
      read_gnt_q   <= 1'b0;
      packet_out_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      write_gnt_q <= wa;
      read_gnt_q  <= ra;
      if (ra)      packet_out_q <= mem_q[raddr];
      if (ovf_set) overflow_q   <= 1'b1;
      if (udf_set) underflow_q  <= 1'b1;
    end
  end

  // Write pacing: in pulse mode a held request is granted once, re-armed by a low cycle.
  always_ff @(posedge clk) begin
    if (rst || PULSE_GNT == 0) begin
      wr_en_q <= 1'b1;
    end else if (wa) begin
      wr_en_q <= 1'b0;
    end else if (!bus.write_req) begin
      wr_en_q <= 1'b1;
    end
  end

  // Flit storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wa) mem_q[waddr] <= bus.packet_in;
  end

  assign bus.write_gnt     = write_gnt_q;
  assign bus.read_gnt      = read_gnt_q;
  assign bus.packet_out    = packet_out_q;
  assign bus.full          = full_c;
  assign bus.empty         = empty_c;
  assign bus.almost_full   = af_c;
  assign bus.count         = count_c;
  assign bus.overflow_err  = overflow_q;
  assign bus.underflow_err = underflow_q;
endmodule

// File: tb/tb_vc_fifo.sv
// Bench for vc_fifo: one pulse-mode and one streaming-mode instance share the same
// stimulus; a queue-based model of each is checked every cycle.
module tb_vc_fifo;
  localparam int DW = 36;
  localparam int NV = 4;
  localparam int D  = 16;
  localparam int AF = 2;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          wreq = 1'b0, rreq = 1'b0;
  logic [1:0]    wvc = '0, rvc = '0;
  logic [DW-1:0] din = '0;

  vc_fifo_if #(.DATA_W(DW), .VC_NUM(NV), .VC_DEPTH(D)) bus_p ();
  vc_fifo_if #(.DATA_W(DW), .VC_NUM(NV), .VC_DEPTH(D)) bus_s ();

  assign bus_p.write_req = wreq;
  assign bus_p.write_vc  = wvc;
  assign bus_p.packet_in = din;
  assign bus_p.read_req  = rreq;
  assign bus_p.read_vc   = rvc;
  assign bus_s.write_req = wreq;
  assign bus_s.write_vc  = wvc;
  assign bus_s.packet_in = din;
  assign bus_s.read_req  = rreq;
  assign bus_s.read_vc   = rvc;

  vc_fifo #(.DATA_W(DW), .VC_NUM(NV), .VC_DEPTH(D), .AF_LEVEL(AF), .PULSE_GNT(1)) dut_p (
    .clk(clk), .rst(rst), .bus(bus_p)
  );
  vc_fifo #(.DATA_W(DW), .VC_NUM(NV), .VC_DEPTH(D), .AF_LEVEL(AF), .PULSE_GNT(0)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue per (instance, VC); index = inst*NV + vc.
  logic [DW-1:0] mq [2*NV][$];
  bit            wen_m [2];
  bit            wg_m  [2];
  bit            rg_m  [2];
  bit            ov_m  [2];
  bit            un_m  [2];
  logic [DW-1:0] po_m  [2];

  task automatic model_step(int m, bit pulse);
    int  kw, kr;
    bit  fl, em, wa, ra;
    if (rst) begin
      for (int v = 0; v < NV; v++) mq[m*NV+v].delete();
      wen_m[m] = 1; wg_m[m] = 0; rg_m[m] = 0; ov_m[m] = 0; un_m[m] = 0; po_m[m] = '0;
      return;
    end
    kw = m*NV + int'(wvc);
    kr = m*NV + int'(rvc);
    fl = (mq[kw].size() == D);
    em = (mq[kr].size() == 0);
    wa = wreq && !fl && wen_m[m];
    ra = rreq && !em;
    if (wreq && fl && wen_m[m]) ov_m[m] = 1;
    if (rreq && em) un_m[m] = 1;
    if (ra) po_m[m] = mq[kr].pop_front();
    if (wa) mq[kw].push_back(din);
    wg_m[m] = wa;
    rg_m[m] = ra;
    if (!pulse) wen_m[m] = 1;
    else if (wa) wen_m[m] = 0;
    else if (!wreq) wen_m[m] = 1;
  endtask

  // Advance both models with the inputs the DUTs sample on this edge.
  always @(posedge clk) begin
    model_step(0, 1'b1);
    model_step(1, 1'b0);
  end

  task automatic cmp_inst(int m, logic [NV-1:0] f, logic [NV-1:0] e, logic [NV-1:0] af,
                          logic [NV*CW-1:0] c, logic wg, logic rg, logic [DW-1:0] po,
                          logic ov, logic un);
    logic [NV-1:0]    xf, xe, xaf;
    logic [NV*CW-1:0] xc;
    for (int v = 0; v < NV; v++) begin
      int sz;
      sz = mq[m*NV+v].size();
      xf[v]  = (sz == D);
      xe[v]  = (sz == 0);
      xaf[v] = ((D - sz) <= AF);
      xc[v*CW +: CW] = CW'(sz);
    end
    chk($sformatf("m%0d full", m), f, xf);
    chk($sformatf("m%0d empty", m), e, xe);
    chk($sformatf("m%0d almost_full", m), af, xaf);
    chk($sformatf("m%0d count", m), c, xc);
    chk($sformatf("m%0d write_gnt", m), wg, wg_m[m]);
    chk($sformatf("m%0d read_gnt", m), rg, rg_m[m]);
    chk($sformatf("m%0d packet_out", m), po, po_m[m]);
    chk($sformatf("m%0d overflow_err", m), ov, ov_m[m]);
    chk($sformatf("m%0d underflow_err", m), un, un_m[m]);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp_inst(0, bus_p.full, bus_p.empty, bus_p.almost_full, bus_p.count, bus_p.write_gnt,
               bus_p.read_gnt, bus_p.packet_out, bus_p.overflow_err, bus_p.underflow_err);
      cmp_inst(1, bus_s.full, bus_s.empty, bus_s.almost_full, bus_s.count, bus_s.write_gnt,
               bus_s.read_gnt, bus_s.packet_out, bus_s.overflow_err, bus_s.underflow_err);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One write with a trailing idle cycle so pulse mode re-arms.
  task automatic wr1(logic [1:0] vc, logic [DW-1:0] d);
    wreq = 1'b1; wvc = vc; din = d;
    cyc();
    wreq = 1'b0;
    cyc();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    cyc();
    chk_on = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("rst empty", bus_p.empty, 4'hf);
    chk("rst full", bus_p.full, 4'h0);
    chk("rst count", bus_p.count, 20'h0);
    chk("rst gnts", {bus_p.write_gnt, bus_p.read_gnt}, 2'b00);
    chk("rst packet_out", bus_p.packet_out, 36'h0);
    chk("rst errors", {bus_s.overflow_err, bus_s.underflow_err}, 2'b00);

    // Held request: one grant in pulse mode, one per cycle when streaming.
    wreq = 1'b1; wvc = 2'd1; din = 36'h123; n = 0;
    repeat (5) begin
      cyc();
      if (bus_p.write_gnt) n++;
    end
    chk("pulse grant count", n, 1);
    chk("pulse count1", bus_p.count[1*CW +: CW], 1);
    chk("stream count1", bus_s.count[1*CW +: CW], 5);
    wreq = 1'b0;
    cyc();
    wreq = 1'b1;
    cyc();
    chk("pulse regrant", bus_p.write_gnt, 1);
    chk("pulse count1 again", bus_p.count[1*CW +: CW], 2);
    chk("stream count1 again", bus_s.count[1*CW +: CW], 6);
    wreq = 1'b0;
    cyc();

    // Stream VC2 to full and one beyond.
    wreq = 1'b1; wvc = 2'd2;
    for (int i = 1; i <= 17; i++) begin
      din = DW'(i);
      cyc();
      if (i == 13) chk("af at 13", bus_s.almost_full[2], 0);
      if (i == 14) chk("af at 14", bus_s.almost_full[2], 1);
      if (i == 16) chk("full at 16", {bus_s.full[2], bus_s.write_gnt}, 2'b11);
      if (i == 17) chk("17th rejected", {bus_s.write_gnt, bus_s.overflow_err}, 2'b01);
    end
    chk("pulse no overflow", bus_p.overflow_err, 0);
    wreq = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();

    // FIFO order across the pointer wrap on VC0.
    for (int i = 0; i < 16; i++) wr1(2'd0, DW'(i));
    chk("vc0 full", {bus_p.full[0], bus_s.full[0]}, 2'b11);
    rreq = 1'b1; rvc = 2'd0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("wrap read a", {bus_p.read_gnt, bus_p.packet_out}, {1'b1, DW'(i)});
    end
    rreq = 1'b0;
    cyc();
    for (int i = 16; i < 24; i++) wr1(2'd0, DW'(i));
    rreq = 1'b1;
    for (int i = 8; i < 24; i++) begin
      cyc();
      chk("wrap read b", {bus_s.read_gnt, bus_s.packet_out}, {1'b1, DW'(i)});
    end
    rreq = 1'b0;
    cyc();
    chk("vc0 empty after wrap", {bus_p.empty[0], bus_s.empty[0]}, 2'b11);

    // Same-VC read and write with one entry, then read of an empty VC.
    wr1(2'd3, 36'hABC);
    wreq = 1'b1; wvc = 2'd3; din = 36'hDEF; rreq = 1'b1; rvc = 2'd3;
    cyc();
    chk("same vc grants", {bus_p.write_gnt, bus_p.read_gnt}, 2'b11);
    chk("same vc data", bus_p.packet_out, 36'hABC);
    chk("same vc count", bus_p.count[3*CW +: CW], 1);
    wreq = 1'b0; rvc = 2'd0;
    cyc();
    chk("empty read", {bus_p.read_gnt, bus_p.underflow_err}, 2'b01);
    chk("empty read holds data", bus_p.packet_out, 36'hABC);
    rreq = 1'b0;
    cyc();

    // Reset with VC1 loaded and a read grant outstanding.
    for (int i = 0; i < 5; i++) wr1(2'd1, 36'h500 + DW'(i));
    rreq = 1'b1; rvc = 2'd1;
    cyc();
    chk("read in flight", {bus_p.read_gnt, bus_p.packet_out}, {1'b1, 36'h500});
    rst = 1'b1; rreq = 1'b0;
    cyc();
    rst = 1'b0;
    chk("mid rst count", bus_p.count, 20'h0);
    chk("mid rst outs", {bus_p.read_gnt, bus_p.packet_out}, 37'h0);
    chk("mid rst errors", {bus_p.overflow_err, bus_p.underflow_err}, 2'b00);
    cyc();

    // Randomised traffic with write-heavy and read-heavy phases.
    for (int k = 0; k < 3000; k++) begin
      bit wheavy;
      wheavy = ((k / 250) % 2) == 0;
      wreq = wheavy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rreq = wheavy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      wvc  = ($urandom_range(0, 1) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom);
      rvc  = 2'($urandom);
      din  = {4'($urandom), $urandom};
      rst  = ($urandom_range(0, 399) == 0);
      cyc();
    end
    rst = 1'b0; wreq = 1'b0; rreq = 1'b0;
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
